ipsxe_floating_point_rr_sched_4ch_v1_0: RTL and testbench

Round-robin scheduler that shares one in-order floating-point operator pipeline (fed through the blocking-mode AXI buffer) among 4 requester channels. It arbitrates requester operand bundles onto a single registered AXI-Stream master port and tags each accepted transfer with its channel ID. It returns operator results to the originating channel using an in-order ID FIFO. Sits between the requester-side stream muxing and the operator's input buffer/result port.

---
 rtl/ipsxe_floating_point_rr_sched_4ch_v1_0.sv | 173 +++++++++++++++++
 tb/tb_ipsxe_floating_point_rr_sched_4ch_v1_0.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_floating_point_rr_sched_4ch_v1_0.sv
// ---------------------------------------------------------------------------
// ipsxe_floating_point_rr_sched_4ch_v1_0
//
// Purpose:
//   Shares one in-order floating-point operator pipeline among four requester
//   channels. A round-robin arbiter moves requester operand bundles into a
//   registered AXI-Stream output stage and tags each transfer with its channel
//   ID. The operator returns results in issue order, so each accepted ID is
//   pushed into a small FIFO. The FIFO head then steers each returning result
//   back to the channel that issued it.
//
// Ports:
//   i_aclk, i_areset_n      clock (rising edge) and synchronous active-low reset
//   i_s_tdata/tvalid        four requester bundles (channel k at k*DATA_WIDTH)
//   o_s_tready              one-hot-or-zero grant to requesters (combinational)
//   o_m_tdata/tid/tvalid    registered bundle and channel ID to the operator buffer
//   i_m_tready              operator buffer ready
//   i_r_tdata/tvalid        result from the operator
//   o_r_tready              result ready to the operator (combinational)
//   o_r_tdata               result data broadcast to all requesters
//   o_r_tvalid              per-channel result valid (one-hot or zero)
//   i_r_tready              per-channel result ready
//   o_outstanding           tags issued and not yet returned
//   o_busy                  output stage full or operations still in flight
//   o_err_orphan            sticky flag: a result arrived with no tag to match
// ---------------------------------------------------------------------------
module ipsxe_floating_point_rr_sched_4ch_v1_0 #(
    parameter int DATA_WIDTH    = 66,
    parameter int RES_WIDTH     = 33,
    parameter int ID_FIFO_DEPTH = 16,
    parameter int ID_ADDR_WIDTH = 4
) (
    input  logic                      i_aclk,
    input  logic                      i_areset_n,
    input  logic [4*DATA_WIDTH-1:0]   i_s_tdata,
    input  logic [3:0]                i_s_tvalid,
    output logic [3:0]                o_s_tready,
    output logic [DATA_WIDTH-1:0]     o_m_tdata,
    output logic [1:0]                o_m_tid,
    output logic                      o_m_tvalid,
    input  logic                      i_m_tready,
    input  logic [RES_WIDTH-1:0]      i_r_tdata,
    input  logic                      i_r_tvalid,
    output logic                      o_r_tready,
    output logic [RES_WIDTH-1:0]      o_r_tdata,
    output logic [3:0]                o_r_tvalid,
    input  logic [3:0]                i_r_tready,
    output logic [ID_ADDR_WIDTH:0]    o_outstanding,
    output logic                      o_busy,
    output logic                      o_err_orphan
);

    localparam logic [ID_ADDR_WIDTH:0] LP_FULL_COUNT = (ID_ADDR_WIDTH+1)'(ID_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]    r_m_tdata;
    logic [1:0]               r_m_tid;
    logic                     r_m_tvalid;
    logic [1:0]               r_rr_ptr;
    logic [1:0]               r_id_mem [ID_FIFO_DEPTH];
    logic [ID_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ID_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ID_ADDR_WIDTH:0]   r_count;
    logic                     r_err_orphan;

    logic [1:0] w_pick;
    logic [1:0] w_scan_idx;
    logic       w_any_valid;
    logic       w_id_full;
    logic       w_id_empty;
    logic       w_can_issue;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_head;

    // Full comes from the registered count only, so a pop in the same cycle
    // does not allow an accept until the next cycle.
    assign w_id_full  = (r_count == LP_FULL_COUNT);
    assign w_id_empty = (r_count == '0);
    assign w_head     = r_id_mem[r_rd_ptr];

    // Scan from the highest offset down so the last hit is the channel
    // closest to the round-robin pointer.
    always_comb begin
        w_pick      = 2'd0;
        w_any_valid = 1'b0;
        w_scan_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_scan_idx = r_rr_ptr + 2'(i);
            if (i_s_tvalid[w_scan_idx]) begin
                w_pick      = w_scan_idx;
                w_any_valid = 1'b1;
            end
        end
    end

    assign w_can_issue = i_areset_n & (~r_m_tvalid | i_m_tready) & ~w_id_full;
    assign w_push      = w_can_issue & w_any_valid;
    assign o_s_tready  = w_push ? (4'b0001 << w_pick) : 4'b0000;

    // With no tag pending, the operator is told to drop the result (ready
    // high) so it cannot stall forever. The orphan flag records the event.
    always_comb begin
        o_r_tvalid = 4'b0000;
        o_r_tready = 1'b0;
        if (i_areset_n) begin
            if (w_id_empty) begin
                o_r_tready = 1'b1;
            end else begin
                o_r_tvalid = {3'b000, i_r_tvalid} << w_head;
                o_r_tready = i_r_tready[w_head];
            end
        end
    end

    assign w_pop     = i_areset_n & ~w_id_empty & i_r_tvalid & o_r_tready;
    assign o_r_tdata = i_r_tdata;

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every always_ff reading the pre-edge value of every register.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_m_tdata    <= '0;
            r_m_tid      <= 2'd0;
            r_m_tvalid   <= 1'b0;
            r_rr_ptr     <= 2'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_m_tdata  <= i_s_tdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
                r_m_tid    <= w_pick;
                r_m_tvalid <= 1'b1;
                r_rr_ptr   <= w_pick + 2'd1;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end else if (i_m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_id_empty && i_r_tvalid) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // NOTE: the tag storage has no reset. Its contents are only read
    // behind the reset-cleared pointers and count, so clearing it would add
    // reset fan-out and serve no purpose.
    always_ff @(posedge i_aclk) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= w_pick;
        end
    end

    assign o_m_tdata     = r_m_tdata;
    assign o_m_tid       = r_m_tid;
    assign o_m_tvalid    = r_m_tvalid;
    assign o_outstanding = r_count;
    assign o_busy        = r_m_tvalid | (r_count != '0);
    assign o_err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_ipsxe_floating_point_rr_sched_4ch_v1_0.sv
// ---------------------------------------------------------------------------
// Directed testbench for ipsxe_floating_point_rr_sched_4ch_v1_0.
// Inputs change on the falling edge. Combinational outputs are sampled 1 ns
// later. Registered outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_ipsxe_floating_point_rr_sched_4ch_v1_0;

    localparam int DW = 66;
    localparam int RW = 33;

    logic           clk = 1'b0;
    logic           areset_n;
    logic [4*DW-1:0] s_tdata;
    logic [3:0]     s_tvalid;
    logic [3:0]     s_tready;
    logic [DW-1:0]  m_tdata;
    logic [1:0]     m_tid;
    logic           m_tvalid;
    logic           m_tready;
    logic [RW-1:0]  r_tdata_in;
    logic           r_tvalid_in;
    logic           r_tready_out;
    logic [RW-1:0]  r_tdata_out;
    logic [3:0]     r_tvalid_out;
    logic [3:0]     r_tready_in;
    logic [4:0]     outstanding;
    logic           busy;
    logic           err_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ipsxe_floating_point_rr_sched_4ch_v1_0 dut (
        .i_aclk        (clk),
        .i_areset_n    (areset_n),
        .i_s_tdata     (s_tdata),
        .i_s_tvalid    (s_tvalid),
        .o_s_tready    (s_tready),
        .o_m_tdata     (m_tdata),
        .o_m_tid       (m_tid),
        .o_m_tvalid    (m_tvalid),
        .i_m_tready    (m_tready),
        .i_r_tdata     (r_tdata_in),
        .i_r_tvalid    (r_tvalid_in),
        .o_r_tready    (r_tready_out),
        .o_r_tdata     (r_tdata_out),
        .o_r_tvalid    (r_tvalid_out),
        .i_r_tready    (r_tready_in),
        .o_outstanding (outstanding),
        .o_busy        (busy),
        .o_err_orphan  (err_orphan)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] bundle(input int k);
        bundle = {2'b10, 56'hDA7A_0000_0000_00, 8'(k)};
    endfunction

    task automatic load_bundles();
        for (int k = 0; k < 4; k++) s_tdata[k*DW +: DW] = bundle(k);
    endtask

    task automatic do_reset();
        areset_n    = 1'b0;
        s_tvalid    = 4'h0;
        m_tready    = 1'b1;
        r_tvalid_in = 1'b0;
        r_tready_in = 4'hF;
        r_tdata_in  = '0;
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n    = 1'b0;
        s_tvalid    = 4'hF;
        m_tready    = 1'b1;
        r_tvalid_in = 1'b1;
        r_tready_in = 4'hF;
        r_tdata_in  = '0;
        load_bundles();
        @(negedge clk);
        @(negedge clk);
        // Reset gating of the combinational outputs and register reset values.
        #1;
        check("rst_s_tready",  128'(s_tready), 128'(4'h0));
        check("rst_r_tvalid",  128'(r_tvalid_out), 128'(4'h0));
        check("rst_r_tready",  128'(r_tready_out), 128'(1'b0));
        check("rst_m_tvalid",  128'(m_tvalid), 128'(1'b0));
        check("rst_m_tdata",   128'(m_tdata), 128'(0));
        check("rst_outstand",  128'(outstanding), 128'(5'd0));
        check("rst_orphan",    128'(err_orphan), 128'(1'b0));
        check("rst_busy",      128'(busy), 128'(1'b0));
        @(negedge clk);

        // ---- Test 1: all channels valid, rotating grants ----
        r_tvalid_in = 1'b0;
        areset_n    = 1'b1;
        s_tvalid    = 4'hF;
        for (int n = 0; n < 8; n++) begin
            #1;
            check("t1_s_tready", 128'(s_tready), 128'(4'b0001 << (n % 4)));
            @(negedge clk);
            check("t1_m_tid",    128'(m_tid), 128'(n % 4));
            check("t1_m_tvalid", 128'(m_tvalid), 128'(1'b1));
            check("t1_m_tdata",  128'(m_tdata), 128'(bundle(n % 4)));
        end
        check("t1_outstand", 128'(outstanding), 128'(5'd8));
        check("t1_busy",     128'(busy), 128'(1'b1));

        // ---- Test 2: channels 1 and 3 with the pointer at 2 ----
        do_reset();
        s_tvalid = 4'b0010;          // one accept from ch1 moves pointer to 2
        #1;
        check("t2_pre_grant", 128'(s_tready), 128'(4'b0010));
        @(negedge clk);
        s_tvalid = 4'b1010;
        #1;
        check("t2_grant3", 128'(s_tready), 128'(4'b1000));
        @(negedge clk);
        check("t2_tid3",   128'(m_tid), 128'(2'd3));
        #1;
        check("t2_grant1", 128'(s_tready), 128'(4'b0010));
        @(negedge clk);
        check("t2_tid1",   128'(m_tid), 128'(2'd1));
        s_tvalid = 4'hF;             // pointer back at 2: ch2 wins
        #1;
        check("t2_ptr2",   128'(s_tready), 128'(4'b0100));
        @(negedge clk);
        s_tvalid = 4'h0;

        // ---- Test 3: output stage holds while the operator stalls ----
        do_reset();
        s_tdata[2*DW +: DW] = 66'h2_1234_5678_9ABC_DEAA;
        s_tvalid = 4'b0100;
        #1;
        check("t3_grant2", 128'(s_tready), 128'(4'b0100));
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("t3_s_tready", 128'(s_tready), 128'(4'h0));
            check("t3_m_tvalid", 128'(m_tvalid), 128'(1'b1));
            check("t3_m_tid",    128'(m_tid), 128'(2'd2));
            check("t3_m_tdata",  128'(m_tdata), 128'(66'h2_1234_5678_9ABC_DEAA));
            @(negedge clk);
        end
        m_tready = 1'b1;
        #1;
        check("t3_resume", 128'(s_tready), 128'(4'b1000));
        @(negedge clk);
        s_tvalid = 4'h0;
        load_bundles();

        // ---- Test 4: full tag FIFO blocks issue, resumes one cycle after pop ----
        do_reset();
        s_tvalid = 4'hF;
        for (int n = 0; n < 16; n++) begin
            #1;
            check("t4_fill", 128'(s_tready), 128'(4'b0001 << (n % 4)));
            @(negedge clk);
        end
        check("t4_outstand16", 128'(outstanding), 128'(5'd16));
        r_tvalid_in = 1'b1;
        r_tdata_in  = 33'h1_0000_0F00;
        #1;
        check("t4_full_block", 128'(s_tready), 128'(4'h0));
        check("t4_pop_valid",  128'(r_tvalid_out), 128'(4'b0001));
        check("t4_pop_ready",  128'(r_tready_out), 128'(1'b1));
        @(negedge clk);
        r_tvalid_in = 1'b0;
        check("t4_outstand15", 128'(outstanding), 128'(5'd15));
        #1;
        check("t4_resume", 128'(s_tready), 128'(4'b0001));
        @(negedge clk);
        check("t4_refill", 128'(outstanding), 128'(5'd16));
        s_tvalid = 4'h0;

        // ---- Test 5: in-order result routing with a stalled requester ----
        do_reset();
        s_tvalid = 4'b0001;
        @(negedge clk);
        s_tvalid = 4'b0100;
        @(negedge clk);
        s_tvalid = 4'b0010;
        #1;
        check("t5_issue_ch1", 128'(s_tready), 128'(4'b0010));
        @(negedge clk);
        s_tvalid = 4'h0;
        check("t5_outstand3", 128'(outstanding), 128'(5'd3));
        r_tvalid_in = 1'b1;
        r_tready_in = 4'b1011;
        r_tdata_in  = 33'h0_0000_00A0;
        #1;
        check("t5_r0_valid", 128'(r_tvalid_out), 128'(4'b0001));
        check("t5_r0_ready", 128'(r_tready_out), 128'(1'b1));
        check("t5_r0_data",  128'(r_tdata_out), 128'(33'h0_0000_00A0));
        @(negedge clk);
        r_tdata_in = 33'h0_0000_00A1;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("t5_r1_hold_valid", 128'(r_tvalid_out), 128'(4'b0100));
            check("t5_r1_hold_ready", 128'(r_tready_out), 128'(1'b0));
            @(negedge clk);
        end
        r_tready_in = 4'hF;
        #1;
        check("t5_r1_valid", 128'(r_tvalid_out), 128'(4'b0100));
        check("t5_r1_ready", 128'(r_tready_out), 128'(1'b1));
        @(negedge clk);
        r_tdata_in = 33'h0_0000_00A2;
        #1;
        check("t5_r2_valid", 128'(r_tvalid_out), 128'(4'b0010));
        check("t5_r2_data",  128'(r_tdata_out), 128'(33'h0_0000_00A2));
        @(negedge clk);
        r_tvalid_in = 1'b0;
        check("t5_drained",   128'(outstanding), 128'(5'd0));
        check("t5_no_orphan", 128'(err_orphan), 128'(1'b0));

        // ---- Test 6: orphan result, then reset with work in flight ----
        r_tvalid_in = 1'b1;
        #1;
        check("t6_orphan_ready", 128'(r_tready_out), 128'(1'b1));
        check("t6_orphan_valid", 128'(r_tvalid_out), 128'(4'h0));
        @(negedge clk);
        r_tvalid_in = 1'b0;
        check("t6_orphan_set", 128'(err_orphan), 128'(1'b1));
        s_tvalid = 4'hF;
        for (int n = 0; n < 5; n++) @(negedge clk);
        check("t6_outstand5", 128'(outstanding), 128'(5'd5));
        check("t6_orphan_sticky", 128'(err_orphan), 128'(1'b1));
        areset_n    = 1'b0;
        r_tvalid_in = 1'b1;
        #1;
        check("t6_rst_s_tready", 128'(s_tready), 128'(4'h0));
        check("t6_rst_r_tready", 128'(r_tready_out), 128'(1'b0));
        check("t6_rst_r_tvalid", 128'(r_tvalid_out), 128'(4'h0));
        @(negedge clk);
        check("t6_rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("t6_rst_m_tdata",  128'(m_tdata), 128'(0));
        check("t6_rst_m_tid",    128'(m_tid), 128'(2'd0));
        check("t6_rst_outstand", 128'(outstanding), 128'(5'd0));
        check("t6_rst_orphan",   128'(err_orphan), 128'(1'b0));
        check("t6_rst_busy",     128'(busy), 128'(1'b0));
        areset_n = 1'b1;
        s_tvalid = 4'h0;
        #1;
        check("t6_post_no_route", 128'(r_tvalid_out), 128'(4'h0));
        @(negedge clk);
        r_tvalid_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
